wide_add_seq: RTL
=================

# wide_add_seq

Multi-byte add/subtract sequencer that time-shares a single external 8-bit ripple-carry `full_adder` slice across a `NUM_BYTES`-wide operation. It processes one byte per clock, least-significant first, and chains the carry through an internal flip-flop. It sits between the ALU control logic and the 8-bit adder slice, letting wide arithmetic reuse one set of 7486/7408/7432 chips instead of replicating them per byte.

## Interface

Parameters:
- `NUM_BYTES`, default 4: operand width in bytes; must be ≥ 2.

Ports:
- `CLK` input 1: single clock; all state changes on rising edge.
- `N_RST` input 1: reset, synchronous and active-low.
- `START` input 1: request a new operation; sampled only in IDLE.
- `SUB` input 1: 0 = add, 1 = subtract (B is one's-complemented).
- `C_IN` input 1: initial carry. Use 1 for plain subtract and for a chained borrow-free subtract.
- `OP_A` input 8·NUM_BYTES: operand A, captured on accepted START.
- `OP_B` input 8·NUM_BYTES: operand B, captured on accepted START.
- `ADD_A` output 8: adder slice A input.
- `ADD_B` output 8: adder slice B input.
- `ADD_C_IN` output 1: adder slice carry-in.
- `ADD_Y` input 8: adder slice sum.
- `ADD_C_OUT` input 1: adder slice carry-out.
- `BUSY` output 1: high in RUN.
- `DONE` output 1: one-cycle pulse when RESULT is final.
- `RESULT` output 8·NUM_BYTES: sum/difference; holds until the next accepted START.
- `C_OUT` output 1: final carry. For subtract, 1 means no borrow.
- `ZERO` output 1: RESULT == 0, valid with DONE and held afterwards.
- `OVF` output 1: signed overflow; present only with `WIDE_ADD_OVF_EN`.

## Operation

- States: IDLE, RUN, FIN.
- Transitions:
  - IDLE→RUN on START.
  - RUN→FIN after the byte with index NUM_BYTES−1.
  - FIN→IDLE unconditionally.
- On accepted START:
  - latch OP_A and OP_B into operand registers (B inverted if SUB);
  - load the carry register from C_IN;
  - clear the byte index to 0;
  - clear RESULT, C_OUT, ZERO and OVF.
- RUN, byte index i:
  - ADD_A = A[8i+7:8i]; ADD_B = B'[8i+7:8i]; ADD_C_IN = carry register. All driven from registers only, with no combinational path from inputs.
  - At the clock edge: RESULT[8i+7:8i] ← ADD_Y; carry ← ADD_C_OUT; i ← i+1.
- FIN:
  - DONE = 1 and C_OUT = carry register.
  - ZERO = (RESULT == 0), registered on entry to FIN.
- Outside RUN, ADD_A/ADD_B are 0x00 and ADD_C_IN is 0.
- Arithmetic is modulo 2^(8·NUM_BYTES). The byte index counter is ⌈log2 NUM_BYTES⌉ bits, and its terminal compare is against NUM_BYTES−1, never by wrap-around.

## Timing

- Reset (N_RST low at an edge):
  - state → IDLE;
  - BUSY, DONE, C_OUT, ZERO, OVF = 0;
  - RESULT = 0;
  - ADD_* = 0.
- Reset overrides everything, including mid-RUN. A partial RESULT is discarded (zeroed).
- START high at edge k (in IDLE):
  - BUSY = 1 from cycle k+1 through k+NUM_BYTES.
  - Byte i is presented to the slice during cycle k+1+i.
  - DONE = 1 during cycle k+1+NUM_BYTES only.
  - Total latency is NUM_BYTES+1 cycles.
- START while in RUN or FIN is ignored, with no queuing. START in the IDLE cycle right after FIN is accepted, giving back-to-back throughput of one op per NUM_BYTES+2 cycles.
- OP_A, OP_B, SUB and C_IN may change freely after the accepting edge.
- The adder slice is combinational. ADD_Y/ADD_C_OUT must settle within one clock period of the ADD_* register outputs.

## Configuration

- `WIDE_ADD_OVF_EN` defined: the OVF port exists.
  - In FIN, OVF = (A_msb == B'_msb) && (RESULT_msb != A_msb), using the top-byte operand bits actually presented to the slice.
  - OVF is held until the next accepted START and cleared by reset.
- `WIDE_ADD_OVF_EN` undefined: the OVF port and its logic are absent. All other behaviour is identical.

## Test plan

All cases use NUM_BYTES=4.
- Add with carry ripple: OP_A=0x000000FF, OP_B=0x00000001, SUB=0, C_IN=0, START at edge k → BUSY cycles k+1..k+4; DONE only at k+5; RESULT=0x00000100; C_OUT=0; ZERO=0.
- Full-width carry-out: 0xFFFFFFFF + 0x00000001, C_IN=0 → RESULT=0x00000000, C_OUT=1, ZERO=1.
- Subtract with borrow: SUB=1, C_IN=1, 0x00000005 − 0x00000007 → RESULT=0xFFFFFFFE, C_OUT=0. Same with 7 − 5 → RESULT=0x00000002, C_OUT=1.
- START ignored while busy: second START (OP_A=0x11111111) at k+2 → RESULT is still the first op's value, exactly one DONE pulse, and BUSY drops after k+4.
- Reset mid-op: N_RST low at k+3 → next cycle BUSY=0, DONE=0, RESULT=0, ADD_*=0. A subsequent START completes normally.
- With `WIDE_ADD_OVF_EN`: 0x7FFFFFFF + 0x00000001 → OVF=1, RESULT=0x80000000. With 0x00000001 + 0x00000001 → OVF=0.

Source files
------------

// File: rtl/wide_add_seq_if.sv
// Bus bundle for wide_add_seq: operation request/result side plus the
// 8-bit adder slice side. With WIDE_ADD_OVF_EN defined the OVF flag is present.
interface wide_add_seq_if #(
   parameter int unsigned NUM_BYTES = 4
) ();
   localparam int unsigned W = 8 * NUM_BYTES;

   logic         START;
   logic         SUB;
   logic         C_IN;
   logic [W-1:0] OP_A;
   logic [W-1:0] OP_B;
   logic [7:0]   ADD_A;
   logic [7:0]   ADD_B;
   logic         ADD_C_IN;
   logic [7:0]   ADD_Y;
   logic         ADD_C_OUT;
   logic         BUSY;
   logic         DONE;
   logic [W-1:0] RESULT;
   logic         C_OUT;
   logic         ZERO;
`ifdef WIDE_ADD_OVF_EN
   logic         OVF;
`endif

   // Requester and adder-slice side (drives operands, slice sum).
   modport master (
      output START, SUB, C_IN, OP_A, OP_B, ADD_Y, ADD_C_OUT,
      input  ADD_A, ADD_B, ADD_C_IN, BUSY, DONE, RESULT, C_OUT, ZERO
`ifdef WIDE_ADD_OVF_EN
      , input OVF
`endif
   );

   // Sequencer side.
   modport slave (
      input  START, SUB, C_IN, OP_A, OP_B, ADD_Y, ADD_C_OUT,
      output ADD_A, ADD_B, ADD_C_IN, BUSY, DONE, RESULT, C_OUT, ZERO
`ifdef WIDE_ADD_OVF_EN
      , output OVF
`endif
   );
endinterface

// File: rtl/wide_add_seq.sv
// wide_add_seq: multi-byte add/subtract that reuses one external 8-bit
// adder slice, one byte per clock, LSB first, carry chained in a flop.
// Optional feature macro: WIDE_ADD_OVF_EN (adds the signed overflow flag OVF).
module wide_add_seq #(
   parameter int unsigned NUM_BYTES = 4
) (
   input logic           CLK,
   input logic           N_RST,
   wide_add_seq_if.slave bus
);
   localparam int unsigned W     = 8 * NUM_BYTES;
   localparam int unsigned IDX_W = $clog2(NUM_BYTES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [W-1:0]     r_a;        // shifts right one byte per RUN cycle
   logic [W-1:0]     r_b;        // B or ~B, shifts like r_a
   logic             r_carry;    // carry chain; zero outside RUN
   logic [IDX_W-1:0] r_idx;
   logic [W-1:0]     r_result;
   logic [W-1:0]     w_result_next;
   logic             r_busy;
   logic             r_done;
   logic             r_c_out;
   logic             r_zero;
   logic             w_last;
`ifdef WIDE_ADD_OVF_EN
   logic             r_ovf;
`endif

   assign w_last = (r_idx == LAST_IDX);

   // State register.
   always_ff @(posedge CLK) begin
      if (!N_RST) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   // Next-state logic.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (bus.START) w_state_next = ST_RUN;
         ST_RUN:  if (w_last)    w_state_next = ST_FIN;
         ST_FIN:                 w_state_next = ST_IDLE;
         default:                w_state_next = ST_IDLE;
      endcase
   end

   // RESULT with the current slice sum merged into byte r_idx.
   always_comb begin
      w_result_next = r_result;
      for (int i = 0; i < int'(NUM_BYTES); i++) begin
         if (r_idx == IDX_W'(i)) w_result_next[8*i +: 8] = bus.ADD_Y;
      end
   end

   // Datapath: operand capture, byte stepping, result and flag registers.
   always_ff @(posedge CLK) begin
      if (!N_RST) begin
         r_a      <= '0;
         r_b      <= '0;
         r_carry  <= 1'b0;
         r_idx    <= '0;
         r_result <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_c_out  <= 1'b0;
         r_zero   <= 1'b0;
`ifdef WIDE_ADD_OVF_EN
         r_ovf    <= 1'b0;
`endif
      end else begin
         r_busy <= (w_state_next == ST_RUN);
         r_done <= (w_state_next == ST_FIN);
         case (r_state)
            ST_IDLE: begin
               if (bus.START) begin
                  r_a      <= bus.OP_A;
                  r_b      <= bus.SUB ? ~bus.OP_B : bus.OP_B;
                  r_carry  <= bus.C_IN;
                  r_idx    <= '0;
                  r_result <= '0;
                  r_c_out  <= 1'b0;
                  r_zero   <= 1'b0;
`ifdef WIDE_ADD_OVF_EN
                  r_ovf    <= 1'b0;
`endif
               end
            end
            ST_RUN: begin
               // Zero-fill keeps ADD_A/ADD_B at 0x00 once all bytes are consumed.
               r_a      <= {8'h00, r_a[W-1:8]};
               r_b      <= {8'h00, r_b[W-1:8]};
               r_result <= w_result_next;
               if (w_last) begin
                  r_idx   <= '0;
                  r_carry <= 1'b0;
                  r_c_out <= bus.ADD_C_OUT;
                  r_zero  <= (w_result_next == '0);
`ifdef WIDE_ADD_OVF_EN
                  r_ovf   <= (r_a[7] == r_b[7]) && (bus.ADD_Y[7] != r_a[7]);
`endif
               end else begin
                  r_idx   <= r_idx + IDX_W'(1);
                  r_carry <= bus.ADD_C_OUT;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.ADD_A    = r_a[7:0];
   assign bus.ADD_B    = r_b[7:0];
   assign bus.ADD_C_IN = r_carry;
   assign bus.BUSY     = r_busy;
   assign bus.DONE     = r_done;
   assign bus.RESULT   = r_result;
   assign bus.C_OUT    = r_c_out;
   assign bus.ZERO     = r_zero;
`ifdef WIDE_ADD_OVF_EN
   assign bus.OVF      = r_ovf;
`endif

endmodule
